// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state codes,
// default reset vector, sequential step and instruction width.
package fetch_pkg;

    localparam int INSTR_W = 32;

    localparam logic [1:0] FS_IDLE  = 2'd0;
    localparam logic [1:0] FS_ISSUE = 2'd1;
    localparam logic [1:0] FS_WAIT  = 2'd2;
    localparam logic [1:0] FS_DRAIN = 2'd3;

    localparam logic [31:0] RESET_VECTOR_DFLT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DFLT      = 32'd4;

endpackage

// File: rtl/fetch_pc_sequencer_out_reg.sv
// Single-entry output register holding the fetched instruction for decode.
// Clear (flush) beats load, load beats consume.
module fetch_out_reg
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               consume_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [31:0]        pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Instruction-fetch sequencer: owns the pc, keeps at most one fetch in flight,
// resolves trap > redirect flushes and drops stale responses.
// Optional build macro FETCH_MISALIGN_CHK_EN adds the fetch_misaligned output.
module fetch_pc_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DFLT,
    parameter logic [31:0] PC_STEP      = PC_STEP_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               trap_valid,
    input  logic [31:0]        trap_vector,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic               fetch_misaligned,
`endif
    output logic [31:0]        pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        flush;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        can_accept;
    logic        consume;
    logic        fill_load;
    logic        fetch_blocked;

    assign flush      = trap_valid | redirect_valid;
    assign target_raw = trap_valid ? trap_vector : redirect_pc;
    assign can_accept = !instr_valid || !stall;
    assign consume    = instr_valid && !stall;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misaligned_q;

    assign target = target_raw;

    // Latched on every flush so only an aligned target re-enables fetching.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned_q <= 1'b0;
        end else if (flush) begin
            misaligned_q <= |target_raw[1:0];
        end
    end

    assign fetch_misaligned = misaligned_q;
    assign fetch_blocked    = misaligned_q;
`else
    assign target        = target_raw & ~32'h0000_0003;
    assign fetch_blocked = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_IDLE:  state_d = FS_ISSUE;
            FS_ISSUE: if (imem_req && imem_gnt) state_d = FS_WAIT;
            FS_WAIT: begin
                if (imem_rvalid)    state_d = FS_ISSUE;
                else if (flush)     state_d = FS_DRAIN;
            end
            // A response arriving here belongs to a flushed request.
            FS_DRAIN: if (imem_rvalid) state_d = FS_ISSUE;
            default:  state_d = FS_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        fill_load = 1'b0;
        case (state_q)
            FS_ISSUE: imem_req  = can_accept && !flush && !fetch_blocked;
            FS_WAIT:  fill_load = imem_rvalid && !flush;
            default: begin
                imem_req  = 1'b0;
                fill_load = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (flush) begin
            pc_d = target;
        end else if (imem_req && imem_gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_VECTOR;
            req_pc_q <= '0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (fill_load),
        .consume_i (consume),
        .clear_i   (flush),
        .instr_i   (imem_rdata),
        .pc_i      (req_pc_q),
        .valid_o   (instr_valid),
        .instr_o   (instr),
        .pc_o      (instr_pc)
    );

    assign pc        = pc_q;
    assign imem_addr = pc_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer; expected values are hand-derived per scenario.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misaligned;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_pc_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .trap_valid       (trap_valid),
        .trap_vector      (trap_vector),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_misaligned (fetch_misaligned),
`endif
        .pc               (pc),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_pc         (instr_pc)
    );

    // Advance to just after the next rising edge; inputs are driven there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        trap_valid = 1'b0; trap_vector = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) tick();
        checks++;
        if (pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: pc=%h req=%b vld=%b instr=%h ipc=%h, want 0/0/0/0/0",
                     pc, imem_req, instr_valid, instr, instr_pc);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: req=%b want 0", imem_req);
        end
        tick();
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL first_issue: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(k * 4)) begin
                failures++;
                $display("FAIL seq_req[%0d]: req=%b addr=%h want 1/%h", k, imem_req, imem_addr, k * 4);
            end
            imem_gnt = 1'b1;
            tick();
            imem_gnt = 1'b0;
            #1;
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL seq_wait[%0d]: req=%b vld=%b want 0/0", k, imem_req, instr_valid);
            end
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h1000 + 32'(k);
            tick();
            imem_rvalid = 1'b0;
            #1;
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h1000 + 32'(k) || instr_pc !== 32'(k * 4)) begin
                failures++;
                $display("FAIL seq_fill[%0d]: vld=%b instr=%h ipc=%h want 1/%h/%h",
                         k, instr_valid, instr, instr_pc, 32'h1000 + k, k * 4);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_req: req=%b want 0", imem_req);
        end
        imem_gnt = 1'b1;
        repeat (2) tick();
        imem_gnt = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h1002 || instr_pc !== 32'h8 || pc !== 32'hC) begin
            failures++;
            $display("FAIL stall_hold: vld=%b instr=%h ipc=%h pc=%h want 1/00001002/00000008/0000000c",
                     instr_valid, instr, instr_pc, pc);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            failures++;
            $display("FAIL stall_release: req=%b addr=%h want 1/0000000c", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 32'h10) begin
            failures++;
            $display("FAIL stall_consume: vld=%b pc=%h want 0/00000010", instr_valid, pc);
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h200 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL redirect_drain: pc=%h req=%b want 00000200/0", pc, imem_req);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL redirect_drop: vld=%b req=%b addr=%h want 0/1/00000200",
                     instr_valid, imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2000;
        tick();
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h2000 || instr_pc !== 32'h200 || pc !== 32'h204) begin
            failures++;
            $display("FAIL redirect_fill: vld=%b instr=%h ipc=%h pc=%h want 1/00002000/00000200/00000204",
                     instr_valid, instr, instr_pc, pc);
        end
    endtask

    task automatic test_trap_priority();
        trap_valid     = 1'b1;
        trap_vector    = 32'h0000_0100;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        imem_gnt       = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL flush_req: req=%b want 0", imem_req);
        end
        tick();
        trap_valid = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h100 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL trap_priority: pc=%h vld=%b req=%b addr=%h want 00000100/0/1/00000100",
                     pc, instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_req: req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pc: pc=%h want 00000000", pc);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3000;
        tick();
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr !== 32'h3000) begin
            failures++;
            $display("FAIL wrap_fill: vld=%b ipc=%h instr=%h want 1/fffffffc/00003000",
                     instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0202;
        tick();
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_CHK_EN
        checks++;
        if (fetch_misaligned !== 1'b1 || pc !== 32'h202 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL misalign_set: mis=%b pc=%h req=%b want 1/00000202/0",
                     fetch_misaligned, pc, imem_req);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (fetch_misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL misalign_clear: mis=%b req=%b addr=%h want 0/1/00000200",
                     fetch_misaligned, imem_req, imem_addr);
        end
`else
        checks++;
        if (pc !== 32'h200 || imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL misalign_mask: pc=%h req=%b addr=%h vld=%b want 00000200/1/00000200/0",
                     pc, imem_req, imem_addr, instr_valid);
        end
`endif
    endtask

    task automatic test_async_reset();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h204 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_wait: pc=%h req=%b want 00000204/0", pc, imem_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0 || instr_pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: pc=%h ipc=%h instr=%h vld=%b want 0/0/0/0",
                     pc, instr_pc, instr, instr_valid);
        end
        tick();
        rst = 1'b1;
        tick();
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_req: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_trap_priority();
        test_wrap();
        test_misalign();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
Instruction-fetch controller that owns the program counter and sequences it into instruction memory. It issues fetch requests and holds one outstanding transaction at most. Results land in a single-entry output register read by decode. Decode stalls, branch/jump redirects and trap entries are resolved with a fixed priority, and stale responses are discarded after a flush.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment for sequential fetch.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
stall  in  1  decode cannot accept; output register holds.
redirect_valid  in  1  branch/jump taken this cycle.
redirect_pc  in  32  redirect target.
trap_valid  in  1  trap entry this cycle.
trap_vector  in  32  trap target.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address (equals pc).
imem_gnt  in  1  memory accepted request this cycle.
imem_rvalid  in  1  response valid, in order.
imem_rdata  in  32  response instruction.
pc  out  32  address of next fetch.
instr_valid  out  1  output register holds an instruction.
instr  out  32  fetched instruction.
instr_pc  out  32  address of instr.

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_VECTOR, state=IDLE, instr_valid=0, instr=0, instr_pc=0, req_pc=0, imem_req=0.
- flush = trap_valid | redirect_valid. target = trap_vector if trap_valid, else redirect_pc. Trap wins over redirect.
- can_accept = !instr_valid | !stall.
- A consume happens on instr_valid & !stall.
- States: IDLE, ISSUE, WAIT, DRAIN (2-bit encoding).
- IDLE: imem_req=0. The first cycle after reset release goes to ISSUE.
- ISSUE:
  - imem_req = can_accept & !flush. This is combinational; imem_addr=pc.
  - On imem_req & imem_gnt: req_pc<=pc, pc<=pc+PC_STEP (mod 2^32, wraps FFFF_FFFC->0000_0000), go to WAIT.
  - A request may be withdrawn before grant.
- WAIT: imem_req=0.
  - On imem_rvalid with no flush: instr<=imem_rdata, instr_pc<=req_pc, instr_valid<=1, go to ISSUE.
  - Output register is guaranteed empty here because issue required can_accept.
- DRAIN: imem_req=0. On imem_rvalid the data is discarded and the state goes to ISSUE.
- Flush, any state: pc<=target, instr_valid<=0.
  - From WAIT without rvalid, go to DRAIN.
  - From WAIT with rvalid in the same cycle, discard and go to ISSUE.
  - From ISSUE, no grant is possible in the flush cycle; stay in ISSUE.
  - From DRAIN, stay in DRAIN.
- Consume without a new fill: instr_valid<=0. Otherwise instr/instr_pc hold.
- Latency: grant at cycle N and rvalid at cycle M give instr_valid=1 at M+1. Best case is one instruction every 2 cycles.
- Reset mid-transaction: the in-flight response is the memory's responsibility to drop. The block returns to IDLE.

Optional Feature:
FETCH_MISALIGN_CHK_EN
- Defined: adds output fetch_misaligned (1 bit, reset 0).
  - A flush target with bits[1:0]!=0 sets fetch_misaligned=1 and still loads pc.
  - While set, imem_req is forced to 0.
  - Cleared by the next flush with an aligned target.
- Undefined: the port is absent, and target bits[1:0] are forced to 2'b00 before loading pc.

Decomposition:
- Shared package fetch_pkg holds:
  - state localparams FS_IDLE/FS_ISSUE/FS_WAIT/FS_DRAIN;
  - default RESET_VECTOR;
  - PC_STEP;
  - INSTR_W=32.
- One sub-module, fetch_out_reg: the instr/instr_pc/instr_valid holding register with load/consume/clear inputs.
- The FSM and pc stay in the top module.

Test Plan:
- Reset release; memory grants immediately with rvalid one cycle later -> IDLE 1 cycle; imem_addr 0x0, 0x4, 0x8; instr_pc matches; instr_valid pulses every 2 cycles.
- stall=1 while instr_valid=1 (instr_pc=0x4) -> imem_req=0; instr/instr_pc stable. Release stall -> request to 0x8 on the next cycle.
- redirect_valid to 0x0000_0200 while in WAIT (request to 0x8 outstanding) -> DRAIN; the rvalid for 0x8 is dropped (instr_valid stays 0); the next request is to 0x200.
- trap_valid (vector 0x100) and redirect_valid (0x300) in the same cycle -> pc=0x100; next imem_addr=0x100.
- pc=0xFFFF_FFFC with grant -> pc wraps to 0x0000_0000; instr_pc=0xFFFF_FFFC.
- Assert rst low mid-WAIT -> outputs reset immediately (asynchronous); after release, the first request is to RESET_VECTOR. With FETCH_MISALIGN_CHK_EN, a redirect to 0x202 sets fetch_misaligned=1 and keeps imem_req=0.
